// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store unit and its store buffer.
package lsu_pkg;

    localparam int LSU_SB_DEPTH = 4;

    typedef enum logic {
        IDLE,
        READ
    } lsu_state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer.sv
// FIFO of pending stores with occupancy tracking.
// The youngest-match search port exists only when LSU_STORE_FWD_EN is defined.
module store_buffer
    import lsu_pkg::*;
#(
    parameter int DEPTH = LSU_SB_DEPTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  sb_entry_t               push_entry,
    output sb_entry_t               head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
`ifdef LSU_STORE_FWD_EN
    ,
    input  logic [7:0]              search_addr,
    output logic                    search_hit,
    output logic [7:0]              search_data
`endif
);

    localparam int PW = $clog2(DEPTH);

    sb_entry_t     entries [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;

    assign head  = entries[head_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + PW'(1);
            if (pop)  head_ptr <= head_ptr + PW'(1);
            if (push && !pop)
                count <= count + (PW+1)'(1);
            else if (pop && !push)
                count <= count - (PW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) entries[tail_ptr] <= push_entry;
    end

`ifdef LSU_STORE_FWD_EN
    logic [PW-1:0] idx;

    // Walk oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        search_hit  = 1'b0;
        search_data = '0;
        idx         = head_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_ptr + PW'(i);
            if (((PW+1)'(i) < count) && (entries[idx].addr == search_addr)) begin
                search_hit  = 1'b1;
                search_data = entries[idx].data;
            end
        end
    end
`endif

endmodule

// File: rtl/load_store_unit.sv
// Load/store front end: buffers stores, drains them in idle cycles, issues loads.
// Store-to-load forwarding is built only when LSU_STORE_FWD_EN is defined.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int SB_DEPTH = LSU_SB_DEPTH
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    output logic [7:0] resp_data,
    output logic       sb_empty,
    output logic       mem_leitura,
    output logic       mem_escrita,
    output logic [7:0] mem_endereco,
    output logic [7:0] mem_entrada,
    input  logic [7:0] mem_saida
);

    lsu_state_t                  state;
    sb_entry_t                   head;
    logic                        sb_full;
    logic                        sb_is_empty;
    logic [$clog2(SB_DEPTH):0]   sb_count;
    logic                        handshake;
    logic                        load_accept;
    logic                        mem_load;
    logic                        fwd_hit;
    logic                        sb_push;
    logic                        sb_pop;
    logic                        load_ok;

`ifdef LSU_STORE_FWD_EN
    logic       search_hit;
    logic [7:0] search_data;
    logic       fwd_pending;
    logic [7:0] fwd_data;

    assign fwd_hit = load_accept && search_hit;
    assign load_ok = !fwd_pending;
`else
    assign fwd_hit = 1'b0;
    assign load_ok = sb_is_empty;
`endif

    assign handshake   = req_valid && req_ready;
    assign load_accept = handshake && !req_write;
    assign mem_load    = load_accept && !fwd_hit;
    assign sb_push     = handshake && req_write;
    assign sb_pop      = !handshake && (state == IDLE) && (sb_count != '0);
    assign sb_empty    = sb_is_empty;

    always_comb begin
        req_ready = 1'b0;
        if (state == IDLE)
            req_ready = req_write ? !sb_full : load_ok;
    end

    store_buffer #(
        .DEPTH(SB_DEPTH)
    ) u_store_buffer (
        .clock      (clock),
        .reset      (reset),
        .push       (sb_push),
        .pop        (sb_pop),
        .push_entry ('{addr: req_addr, data: req_wdata}),
        .head       (head),
        .full       (sb_full),
        .empty      (sb_is_empty),
        .count      (sb_count)
`ifdef LSU_STORE_FWD_EN
        ,
        .search_addr(req_addr),
        .search_hit (search_hit),
        .search_data(search_data)
`endif
    );

    // Forwarded data waits one cycle so both load paths share the same latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            mem_leitura  <= 1'b0;
            mem_escrita  <= 1'b0;
            mem_endereco <= '0;
            mem_entrada  <= '0;
`ifdef LSU_STORE_FWD_EN
            fwd_pending  <= 1'b0;
            fwd_data     <= '0;
`endif
        end else begin
            mem_leitura <= mem_load;
            mem_escrita <= sb_pop;
            if (mem_load)
                mem_endereco <= req_addr;
            else if (sb_pop)
                mem_endereco <= head.addr;
            if (sb_pop)
                mem_entrada <= head.data;

            resp_valid <= 1'b0;
            if (state == READ) begin
                state      <= IDLE;
                resp_valid <= 1'b1;
                resp_data  <= mem_saida;
            end else if (mem_load) begin
                state <= READ;
            end
`ifdef LSU_STORE_FWD_EN
            fwd_pending <= fwd_hit;
            if (fwd_hit)
                fwd_data <= search_data;
            if (fwd_pending) begin
                resp_valid <= 1'b1;
                resp_data  <= fwd_data;
            end
`endif
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store front end between the 8-bit core's execute stage and the data memory. Accepts one load or store request per cycle over a valid/ready port. Posts stores into a small FIFO store buffer and drains it into data memory in idle cycles. Issues loads to memory, or forwards them from the buffer, and returns load data on a one-cycle response strobe.

## Interface
- SB_DEPTH, 4: store-buffer entries; power of two, 2..8
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state
- req_valid  in  1  request present
- req_ready  out  1  request accepted at posedge when valid&&ready; combinational
- req_write  in  1  1 = store, 0 = load
- req_addr  in  8  byte address
- req_wdata  in  8  store data
- resp_valid  out  1  load data valid, one-cycle pulse
- resp_data  out  8  load result
- sb_empty  out  1  store buffer empty
- mem_leitura  out  1  memory read enable (registered)
- mem_escrita  out  1  memory write enable (registered); memory writes on following negedge
- mem_endereco  out  8  memory address (registered)
- mem_entrada  out  8  memory write data (registered)
- mem_saida  in  8  memory read data, combinational from mem_endereco

## Operation
- FSM states: IDLE, READ.
  - IDLE->READ on accepted load that is not forwarded.
  - READ->IDLE unconditionally after one cycle.
- req_ready:
  - store: IDLE and buffer not full.
  - load: IDLE and buffer empty; with forwarding, IDLE only.
  - req_ready is low in READ.
- Store accept: push {addr,data} at tail. No memory access.
- Drain: at a posedge with no handshake, state IDLE and buffer nonempty:
  - pop head;
  - register mem_escrita=1, mem_endereco=head.addr, mem_entrada=head.data for the next cycle.
  - Otherwise mem_escrita=0.
  - Exactly one pop per drain edge.
- Load accept (memory path):
  - register mem_leitura=1 and mem_endereco=req_addr;
  - go to READ;
  - no pop at this edge.
  - At the next posedge, capture mem_saida into resp_data and pulse resp_valid.
- Pointers wrap modulo SB_DEPTH. Occupancy counter width is clog2(SB_DEPTH)+1.
- Full: stores stall, and the next edge drains one entry.
- Reset mid-operation discards buffered stores and any in-flight load. No response is produced.
- Reset values: req_ready=1 (combinational, after reset), resp_valid=0, resp_data=0x00, sb_empty=1, mem_leitura=0, mem_escrita=0, mem_endereco=0x00, mem_entrada=0x00, state IDLE.

## Timing
- Load latency: accept at edge N, resp_valid high during cycle N+1..N+2. Holds for both the memory path and the forwarded path.
- Next load is acceptable at edge N+2 at the earliest.
- Store latency to memory: at least 1 cycle after push. The memory array is updated at the negedge of the drain cycle.
- mem_leitura and mem_escrita are never high in the same cycle.
- Back-to-back stores (SB_DEPTH=4) from empty: 4 accepted; the 5th sees req_ready=0 for one cycle, then is accepted.

## Configuration
- LSU_STORE_FWD_EN defined:
  - Loads are accepted while the buffer is nonempty.
  - Address compare against all valid entries; the youngest match wins.
  - Hit: resp_data=entry data next cycle, no memory read, stay IDLE.
  - Miss: normal memory path. Memory is current because no pending store targets that address.
- Undefined: loads wait for sb_empty. No compare logic is built.

## Structure
- Package lsu_pkg holds:
  - FSM state enum (IDLE, READ);
  - default SB_DEPTH constant;
  - store-entry typedef {addr[7:0], data[7:0]}.
- Sub-module store_buffer:
  - FIFO with push/pop, full/empty and occupancy;
  - youngest-match search port, compiled only under LSU_STORE_FWD_EN.

## Test plan
- Reset pulse mid-traffic -> all outputs at reset values, sb_empty=1, buffered stores lost (a later load of that address returns the old memory value).
- Store 0x10<=0xAB, then load 0x10 (no FWD) -> load stalled until sb_empty=1; resp_data=0xAB one cycle after accept.
- 5 stores back-to-back to 0x20..0x24 with SB_DEPTH=4 -> req_ready drops for exactly one cycle before the 5th; memory ends holding all 5 values in order.
- FWD: stores 0x30<=0x11, 0x30<=0x22, then immediate load 0x30 -> resp_data=0x22 one cycle later, mem_leitura stays 0.
- FWD: pending store to 0x40, load 0x41 (memory holds 0x5A) -> memory read issued, no pop that edge, resp_data=0x5A.
- Address wrap: store 0xFF<=0x77, load 0xFF -> 0x77; drains at address 0xFF with no aliasing to 0x00.
